// File: rtl/gsm_pkg.sv
// gsm_pkg: shared types for the GPIO stimulus/monitor controller.
// The vector record widths are fixed here; the top-level GPIO_W/DWELL_W
// parameters default to these values and must stay equal to them.
package gsm_pkg;

    localparam int GSM_GPIO_W  = 8;
    localparam int GSM_DWELL_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_APPLY,
        ST_DWELL,
        ST_CHECK,
        ST_DONE
    } gsm_state_t;

    typedef struct packed {
        logic [GSM_GPIO_W-1:0]  stim;
        logic [GSM_GPIO_W-1:0]  exp;
        logic [GSM_GPIO_W-1:0]  mask;
        logic [GSM_DWELL_W-1:0] dwell;
    } gsm_vec_t;

    // Table index width: ceil(log2(depth)), never below one bit.
    function automatic int gsm_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gsm_vec_ram.sv
// gsm_vec_ram: vector table, one synchronous write port and one
// asynchronous read port. A read at the address being written in the same
// cycle sees the old entry, since the write lands on the clock edge.
module gsm_vec_ram
    import gsm_pkg::*;
#(
    parameter int NUM_VEC = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  gsm_vec_t      wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output gsm_vec_t      rd_data_o
);

    gsm_vec_t mem_q [NUM_VEC];

    // Table storage; contents survive reset on purpose so a rerun reuses them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/gpio_stim_monitor.sv
// gpio_stim_monitor: holds the CPU in reset, then plays a table of GPIO
// input vectors and checks the masked GPIO output after each one.
// Build option: define GSM_STOP_ON_FAIL_EN to end a run at the first
// mismatching vector instead of playing the whole table.
module gpio_stim_monitor
    import gsm_pkg::*;
#(
    parameter int  NUM_VEC    = 16,
    parameter int  GPIO_W     = GSM_GPIO_W,
    parameter int  DWELL_W    = GSM_DWELL_W,
    parameter int  RST_CYCLES = 4,
    parameter int  TIMEOUT    = 1024,
    parameter int  ERR_W      = 8,
    localparam int AW         = gsm_addr_w(NUM_VEC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AW:0]        run_len,
    input  logic               vec_wr_en,
    input  logic [AW-1:0]      vec_wr_addr,
    input  logic [GPIO_W-1:0]  vec_wr_stim,
    input  logic [GPIO_W-1:0]  vec_wr_exp,
    input  logic [GPIO_W-1:0]  vec_wr_mask,
    input  logic [DWELL_W-1:0] vec_wr_dwell,
    output logic               dut_reset,
    output logic [GPIO_W-1:0]  gpio_in_drv,
    input  logic [GPIO_W-1:0]  gpio_out_obs,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [AW-1:0]      fail_idx,
    output logic [ERR_W-1:0]   err_count
);

    localparam int          LW        = AW + 1;
    localparam int          RCW       = $clog2(RST_CYCLES) + 1;
    localparam int          TCW       = $clog2(TIMEOUT) + 1;
    localparam logic [AW:0] NUM_VEC_L = LW'(NUM_VEC);
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYCLES - 1);
    localparam logic [TCW-1:0] TMO_LOAD = TCW'(TIMEOUT - 1);

    gsm_state_t         state_q;
    logic [AW-1:0]      idx_q;
    logic [AW:0]        len_q;
    logic [RCW-1:0]     rst_cnt_q;
    logic [DWELL_W-1:0] dwell_cnt_q;
    logic [TCW-1:0]     tmo_cnt_q;
    logic               dut_reset_q;
    logic [GPIO_W-1:0]  gpio_in_q;
    logic               busy_q;
    logic               done_q;
    logic [AW-1:0]      fail_idx_q;
    logic [ERR_W-1:0]   err_count_q;

    gsm_vec_t           wr_vec_d;
    gsm_vec_t           rd_vec_d;
    logic [AW:0]        len_clamp_d;
    logic               vec_match_d;
    logic               last_vec_d;
    logic               stop_on_miss_d;

`ifdef GSM_STOP_ON_FAIL_EN
    assign stop_on_miss_d = 1'b1;
`else
    assign stop_on_miss_d = 1'b0;
`endif

    // Pack the write-port fields into one table record.
    always_comb begin
        wr_vec_d       = '0;
        wr_vec_d.stim  = vec_wr_stim;
        wr_vec_d.exp   = vec_wr_exp;
        wr_vec_d.mask  = vec_wr_mask;
        wr_vec_d.dwell = vec_wr_dwell;
    end

    gsm_vec_ram #(
        .NUM_VEC (NUM_VEC),
        .AW      (AW)
    ) u_vec_ram (
        .clk       (clk),
        .wr_en_i   (vec_wr_en && !busy_q),
        .wr_addr_i (vec_wr_addr),
        .wr_data_i (wr_vec_d),
        .rd_addr_i (idx_q),
        .rd_data_o (rd_vec_d)
    );

    assign len_clamp_d = (run_len > NUM_VEC_L) ? NUM_VEC_L : run_len;
    assign vec_match_d = ((gpio_out_obs ^ rd_vec_d.exp) & rd_vec_d.mask) == '0;
    assign last_vec_d  = ({1'b0, idx_q} + 1'b1) == len_q;

    // Run sequencer: reset hold, then apply/dwell/check per vector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            rst_cnt_q   <= '0;
            dwell_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            dut_reset_q <= 1'b0;
            gpio_in_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_idx_q  <= '0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_q       <= '0;
                        len_q       <= len_clamp_d;
                        err_count_q <= '0;
                        fail_idx_q  <= '0;
                        if (len_clamp_d == '0) begin
                            // Empty run: nothing to play, report pass at once.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= ST_RST_HOLD;
                            done_q      <= 1'b0;
                            busy_q      <= 1'b1;
                            dut_reset_q <= 1'b0;
                            rst_cnt_q   <= RST_LOAD;
                        end
                    end
                end
                ST_RST_HOLD: begin
                    if (rst_cnt_q == '0) begin
                        dut_reset_q <= 1'b1;
                        state_q     <= ST_APPLY;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end
                ST_APPLY: begin
                    gpio_in_q   <= rd_vec_d.stim;
                    // A zero dwell still waits one cycle.
                    dwell_cnt_q <= (rd_vec_d.dwell == '0) ? '0 : rd_vec_d.dwell - 1'b1;
                    state_q     <= ST_DWELL;
                end
                ST_DWELL: begin
                    if (dwell_cnt_q == '0) begin
                        tmo_cnt_q <= TMO_LOAD;
                        state_q   <= ST_CHECK;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (vec_match_d || tmo_cnt_q == '0) begin
                        if (!vec_match_d) begin
                            if (err_count_q == '0) begin
                                fail_idx_q <= idx_q;
                            end
                            if (err_count_q != '1) begin
                                err_count_q <= err_count_q + 1'b1;
                            end
                        end
                        if (last_vec_d || (!vec_match_d && stop_on_miss_d)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_APPLY;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_reset   = dut_reset_q;
    assign gpio_in_drv = gpio_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = done_q && (err_count_q == '0);
    assign fail_idx    = fail_idx_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_gpio_stim_monitor.sv
// tb_gpio_stim_monitor: directed and randomized runs of gpio_stim_monitor
// against a run-level model (per-vector cycle cost and error tally).
`timescale 1ns/1ps
module tb_gpio_stim_monitor;

    localparam int NV = 16;
    localparam int GW = 8;
    localparam int DW = 16;
    localparam int RC = 4;
    localparam int TO = 8;
    localparam int EW = 2;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   run_len;
    logic          vec_wr_en;
    logic [AW-1:0] vec_wr_addr;
    logic [GW-1:0] vec_wr_stim;
    logic [GW-1:0] vec_wr_exp;
    logic [GW-1:0] vec_wr_mask;
    logic [DW-1:0] vec_wr_dwell;
    logic          dut_reset;
    logic [GW-1:0] gpio_in_drv;
    logic [GW-1:0] gpio_out_obs;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_idx;
    logic [EW-1:0] err_count;

    logic          loop_mode;
    logic [GW-1:0] obs_fixed;

    logic [7:0]    m_stim [NV];
    logic [7:0]    m_exp  [NV];
    logic [7:0]    m_mask [NV];
    int            m_dwell[NV];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // CPU stand-in: either echoes its GPIO inputs or holds a fixed pattern.
    assign gpio_out_obs = loop_mode ? gpio_in_drv : obs_fixed;

    gpio_stim_monitor #(
        .NUM_VEC    (NV),
        .GPIO_W     (GW),
        .DWELL_W    (DW),
        .RST_CYCLES (RC),
        .TIMEOUT    (TO),
        .ERR_W      (EW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .run_len      (run_len),
        .vec_wr_en    (vec_wr_en),
        .vec_wr_addr  (vec_wr_addr),
        .vec_wr_stim  (vec_wr_stim),
        .vec_wr_exp   (vec_wr_exp),
        .vec_wr_mask  (vec_wr_mask),
        .vec_wr_dwell (vec_wr_dwell),
        .dut_reset    (dut_reset),
        .gpio_in_drv  (gpio_in_drv),
        .gpio_out_obs (gpio_out_obs),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_idx     (fail_idx),
        .err_count    (err_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic write_vec(input int addr, input logic [7:0] s, input logic [7:0] e,
                             input logic [7:0] m, input int d);
        vec_wr_en    = 1'b1;
        vec_wr_addr  = addr[AW-1:0];
        vec_wr_stim  = s;
        vec_wr_exp   = e;
        vec_wr_mask  = m;
        vec_wr_dwell = d[DW-1:0];
        m_stim[addr]  = s;
        m_exp[addr]   = e;
        m_mask[addr]  = m;
        m_dwell[addr] = d;
        @(negedge clk);
        vec_wr_en = 1'b0;
    endtask

    // Run-level expectation: each played vector costs 1 apply cycle,
    // max(dwell,1) wait cycles, and 1 check cycle if it matches or TO if not.
    task automatic model_run(input int len, output int cyc, output int err_e, output int fidx,
                             output logic [7:0] last, output logic pass_e);
        int         lc;
        int         nerr;
        logic [7:0] obs;
        bit         match;
        lc   = (len > NV) ? NV : len;
        nerr = 0;
        fidx = 0;
        last = 8'h00;
        cyc  = (lc > 0) ? RC : 0;
        for (int i = 0; i < lc; i++) begin
            obs   = loop_mode ? m_stim[i] : obs_fixed;
            match = ((obs ^ m_exp[i]) & m_mask[i]) == 8'h00;
            cyc  += 1 + ((m_dwell[i] == 0) ? 1 : m_dwell[i]) + (match ? 1 : TO);
            last  = m_stim[i];
            if (!match) begin
                if (nerr == 0) fidx = i;
                nerr++;
`ifdef GSM_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        err_e  = (nerr > 3) ? 3 : nerr;
        pass_e = (nerr == 0);
    endtask

    // Start a run, optionally pulse start again poke_at cycles in, wait for done.
    task automatic do_run(input int len, input int poke_at, input string tag);
        int         cyc_e, err_e, fidx_e, n, rlow;
        logic [7:0] last_e;
        logic       pass_e, busy_ok;
        model_run(len, cyc_e, err_e, fidx_e, last_e, pass_e);
        run_len = len[AW:0];
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n       = 0;
        rlow    = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 3000) begin
            if (dut_reset === 1'b0) rlow++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == poke_at) begin
                start   = 1'b1;
                run_len = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check_eq({tag, ".cycles"}, n, cyc_e);
        if (len > 0) begin
            check_eq({tag, ".rst_low"}, rlow, RC);
            check_eq({tag, ".busy_held"}, busy_ok, 1);
            check_eq({tag, ".gpio_hold"}, gpio_in_drv, last_e);
            check_eq({tag, ".dut_reset"}, dut_reset, 1);
        end
        check_eq({tag, ".done"}, done, 1);
        check_eq({tag, ".busy"}, busy, 0);
        check_eq({tag, ".err_count"}, err_count, err_e);
        check_eq({tag, ".pass"}, pass, pass_e);
        if (err_e != 0) check_eq({tag, ".fail_idx"}, fail_idx, fidx_e);
        $display("run %-8s len=%0d cycles=%0d/%0d err=%0d fail_idx=%0d pass=%0b",
                 tag, len, n, cyc_e, err_count, fail_idx, pass);
    endtask

    task automatic random_table();
        logic [7:0] s, m, e, src;
        loop_mode = 1'($urandom_range(0, 1));
        obs_fixed = 8'($urandom);
        for (int i = 0; i < NV; i++) begin
            s   = 8'($urandom);
            m   = 8'($urandom);
            src = loop_mode ? s : obs_fixed;
            e   = ($urandom_range(0, 1) == 1) ? src : 8'($urandom);
            write_vec(i, s, e, m, $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        run_len      = '0;
        vec_wr_en    = 1'b0;
        vec_wr_addr  = '0;
        vec_wr_stim  = '0;
        vec_wr_exp   = '0;
        vec_wr_mask  = '0;
        vec_wr_dwell = '0;
        loop_mode    = 1'b1;
        obs_fixed    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst.dut_reset", dut_reset, 0);
        check_eq("rst.gpio_in_drv", gpio_in_drv, 0);
        check_eq("rst.busy", busy, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.pass", pass, 0);
        check_eq("rst.fail_idx", fail_idx, 0);
        check_eq("rst.err_count", err_count, 0);
        $display("reset released, outputs sampled");

        // Single looped-back vector
        loop_mode = 1'b1;
        write_vec(0, 8'h03, 8'h03, 8'hFF, 3);
        do_run(1, -1, "single");

        // Timeout mismatch on vector 1
        loop_mode = 1'b0;
        obs_fixed = 8'h55;
        write_vec(0, 8'h01, 8'h55, 8'hFF, 2);
        write_vec(1, 8'h02, 8'hAA, 8'hFF, 1);
        write_vec(2, 8'h03, 8'h55, 8'hFF, 1);
        do_run(3, -1, "timeout");

        // Empty run straight after a failing one
        do_run(0, -1, "empty");

        // Masked compare with zero dwell
        obs_fixed = 8'hF5;
        write_vec(0, 8'h00, 8'h05, 8'h0F, 0);
        do_run(1, -1, "masked");

        // Over-long run length is clamped to the table depth
        random_table();
        do_run(NV + 5, -1, "clamp");

        // Start pulse during DWELL is ignored
        loop_mode = 1'b1;
        write_vec(0, 8'h5A, 8'h5A, 8'hFF, 10);
        do_run(1, 6, "poke");

        // Saturating error count
        loop_mode = 1'b0;
        obs_fixed = 8'h0F;
        for (int i = 0; i < 5; i++) write_vec(i, 8'(i), 8'hF0, 8'hFF, 1);
        do_run(5, -1, "saturate");

        // Reset during CHECK aborts to IDLE; table survives for a rerun
        write_vec(0, 8'h11, 8'h22, 8'hFF, 1);
        run_len = 5'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("abort.busy_mid", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort.busy", busy, 0);
        check_eq("abort.done", done, 0);
        check_eq("abort.dut_reset", dut_reset, 0);
        check_eq("abort.gpio_in_drv", gpio_in_drv, 0);
        check_eq("abort.err_count", err_count, 0);
        reset = 1'b1;
        @(negedge clk);
        $display("reset applied during CHECK");
        do_run(1, -1, "rerun");

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            random_table();
            do_run($urandom_range(0, NV + 2), -1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
